// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and its consumers.
// The generator takes the master side; the pixel/pattern logic takes the slave side.
interface vga_timing_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             pix_ce;
  logic             hsync;
  logic             vsync;
  logic             vga_sync;
  logic             vga_blank;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  en,
    output pix_ce, hsync, vsync, vga_sync, vga_blank,
    output h_count, v_count, line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_ce, hsync, vsync, vga_sync, vga_blank,
    input  h_count, v_count, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock prescaler,
// run enable and one-cycle line/frame start strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CLK_DIV    = 1,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PW-1:0]    PS_ONE   = PW'(1);
  localparam logic [PW-1:0]    PS_LAST  = PW'(CLK_DIV - 1);
  localparam logic             H_POL    = 1'(H_SYNC_POL);
  localparam logic             V_POL    = 1'(V_SYNC_POL);

  // Counters must be able to represent the last column/line of the raster.
  if (((H_TOTAL - 1) >> CNT_W) != 0 || ((V_TOTAL - 1) >> CNT_W) != 0) begin : g_cnt_w_check
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1) begin : g_clk_div_check
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  logic [PW-1:0]    r_presc;
  logic [CNT_W-1:0] r_h_count;
  logic [CNT_W-1:0] r_v_count;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_blank;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_pix_ce;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;

  assign w_pix_ce = bus.en && (r_presc == PS_LAST);
  assign w_h_wrap = w_pix_ce && (r_h_count == H_LAST);
  assign w_v_wrap = w_h_wrap && (r_v_count == V_LAST);

  always_comb begin
    w_h_next = r_h_count;
    w_v_next = r_v_count;
    if (w_pix_ce) begin
      w_h_next = w_h_wrap ? '0 : r_h_count + CNT_ONE;
      if (w_h_wrap) begin
        w_v_next = w_v_wrap ? '0 : r_v_count + CNT_ONE;
      end
    end
  end

  // Decodes use the next coordinates so sync/blank line up with h/v_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc       <= '0;
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_blank       <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (bus.en) begin
        r_presc <= (r_presc == PS_LAST) ? '0 : r_presc + PS_ONE;
      end
      r_h_count     <= w_h_next;
      r_v_count     <= w_v_next;
      r_hsync       <= (w_h_next >= HS_START && w_h_next < HS_END) ? H_POL : ~H_POL;
      r_vsync       <= (w_v_next >= VS_START && w_v_next < VS_END) ? V_POL : ~V_POL;
      r_blank       <= (w_h_next < H_ACT) && (w_v_next < V_ACT);
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
    end
  end

  assign bus.pix_ce      = w_pix_ce;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.vga_sync    = 1'b1;
  assign bus.vga_blank   = r_blank;
  assign bus.h_count     = r_h_count;
  assign bus.v_count     = r_v_count;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; next generation of the fixed 640x480 controller.
- Timing is generic: front porch, sync, back porch, sync polarity and an integer pixel-clock divider are all parameters.
- Adds a synchronous reset, a run enable, and one-cycle line/frame start strobes.
- Sits between the system clock and the pixel/pattern logic. It drives the VGA connector sync signals and supplies pixel coordinates to the renderer.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of hsync (0 = active-low)
- V_SYNC_POL, 0, asserted level of vsync
- CLK_DIV, 1, clk cycles per pixel (>=1)
- CNT_W, 16, width of the h_count/v_count outputs

Ports:
- clk, in, 1, system clock; all logic is on its rising edge
- rst, in, 1, synchronous active-high reset
- en, in, 1, run enable; low freezes all timing state
- pix_ce, out, 1, pixel strobe: high for one clk cycle per pixel
- hsync, out, 1, horizontal sync at H_SYNC_POL level when asserted
- vsync, out, 1, vertical sync at V_SYNC_POL level when asserted
- vga_sync, out, 1, constant 1
- vga_blank, out, 1, 1 inside the active area, 0 in blanking
- h_count, out, CNT_W, current pixel column, 0..H_TOTAL-1
- v_count, out, CNT_W, current line, 0..V_TOTAL-1
- line_start, out, 1, one-cycle pulse when h_count becomes 0
- frame_start, out, 1, one-cycle pulse when h_count and v_count both become 0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Prescaler counts 0..CLK_DIV-1, wrapping, only while en=1.
  - pix_ce = en AND (prescaler == CLK_DIV-1), combinational from the registered prescaler.
  - With CLK_DIV=1, pix_ce equals en.
- On a clk edge with pix_ce=1:
  - h_count increments. At H_TOTAL-1 it wraps to 0.
  - On that wrap, v_count increments. At V_TOTAL-1 it wraps to 0.
- hsync, vsync, vga_blank, line_start and frame_start are registered. Each is computed from the next counter values, so it is aligned with h_count/v_count in the same cycle: zero latency relative to the coordinates.
  - hsync asserted iff H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync asserted iff V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (default 490..491).
  - vga_blank = (h_count < H_ACTIVE) AND (v_count < V_ACTIVE).
  - line_start = 1 for exactly the one cycle following the pix_ce edge at which h_count wrapped to 0.
  - frame_start = 1 only for the line_start cycle where v_count also wrapped to 0.
  - Both strobes are 0 in all other cycles, including cycles where en is held low at (0,0).
- en=0: prescaler, counters, hsync, vsync and vga_blank all hold. pix_ce, line_start and frame_start are 0. Resuming continues exactly where timing stopped, with no skipped pixels.
- Reset values, applied one edge after rst=1 at any point, including mid-line or mid-frame:
  - prescaler=0, h_count=0, v_count=0
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL
  - vga_blank = 1 (position (0,0) is active)
  - line_start = 0, frame_start = 0
- rst has priority over en.
- h_count and v_count are zero-extended to CNT_W. CNT_W must hold H_TOTAL-1 and V_TOTAL-1; an elaboration-time check flags violation.
- Sync polarity parameters invert only the asserted level; the decoded windows are unchanged.

Test Plan:
- Defaults, CLK_DIV=1, en=1 after reset:
  - hsync low exactly for h_count 656..751 (96 clocks), high otherwise.
  - h_count wraps 799->0. line_start pulses once per 800 clocks.
- Defaults, one full frame:
  - frame_start period is 420000 clocks.
  - vsync low for v_count 490..491 (1600 clocks).
  - vga_blank high for 640*480 = 307200 clocks per frame.
- CLK_DIV=4:
  - pix_ce is high every 4th clk.
  - h_count holds for 4 clocks per value. Line period is 3200 clocks.
- en toggling: drop en for 37 cycles at h_count=100, v_count=3.
  - All outputs hold; strobes stay 0.
  - On resume, h_count continues at 101 and the frame period extends by exactly 37 clocks.
- Reset mid-frame at (700, 491):
  - Next cycle shows h_count=0, v_count=0, hsync=1, vsync=1, vga_blank=1, frame_start=0.
  - First frame_start after release occurs 420000 pixel ticks later.
- Small custom timing with positive polarity: H 4/1/2/1, V 3/1/1/1, H_SYNC_POL=V_SYNC_POL=1.
  - H_TOTAL=8: hsync=1 only at h_count 5..6.
  - V_TOTAL=6: vsync=1 only at v_count 4.
  - frame_start every 48 clocks.
